// File: rtl/sysref_monitor.sv
// SYSREF monitor: edge detect, period/phase measurement, lock tracking, loss counting, optional armed sync.
// Latency: sysref_edge_o, phase_o, period_o, locked_o and sync_o all update 1 cycle after pl_sysref_i is sampled high.
// Backpressure: none; a free-running monitor that observes every cycle and never stalls.
//
// Optional feature: define SYSREF_MON_SYNC_EN to build the arm/sync logic; otherwise armed_o/sync_o are tied 0.
//
// Ports:
//   sysclk_i           SYSREF-aligned system clock (only clock)
//   rst_n_i            asynchronous active-low reset
//   pl_sysref_i        SYSREF already captured in sysclk_i domain
//   expected_period_i  expected period in sysclk_i cycles, 0 disables lock
//   arm_i              single-cycle request to emit sync_o on a later locked edge
//   clr_err_i          single-cycle clear of err_count_o
//   sysref_edge_o      one-cycle pulse per SYSREF rising edge
//   period_o           last measured edge-to-edge period
//   phase_o            cycles since last edge (saturating)
//   locked_o           period stable and equal to expected_period_i
//   err_count_o        saturating count of lock-loss events
//   armed_o            arm pending
//   sync_o             one-cycle sync pulse, coincident with sysref_edge_o
module sysref_monitor #(
    parameter int PERIOD_W   = 16,
    parameter int LOCK_COUNT = 8
) (
    input  logic                sysclk_i,
    input  logic                rst_n_i,
    input  logic                pl_sysref_i,
    input  logic [PERIOD_W-1:0] expected_period_i,
    input  logic                arm_i,
    input  logic                clr_err_i,
    output logic                sysref_edge_o,
    output logic [PERIOD_W-1:0] period_o,
    output logic [PERIOD_W-1:0] phase_o,
    output logic                locked_o,
    output logic [7:0]          err_count_o,
    output logic                armed_o,
    output logic                sync_o
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_TRACK  = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic                sysref_q;
    logic                live_q;
    logic [7:0]          match_q;
    logic [7:0]          match_d;
    logic                err_inc;
    logic                sref_rise;
    logic                phase_max;
    logic                period_ok;
    logic [PERIOD_W-1:0] meas;

    // live_q masks the first cycle after reset release so a SYSREF level
    // that is already high is not mistaken for a rising edge.
    assign sref_rise = pl_sysref_i & ~sysref_q & live_q;
    assign phase_max = &phase_o;
    // Phase counter holds (cycles since edge - 1), so the period is one more.
    assign meas      = phase_o + {{(PERIOD_W-1){1'b0}}, 1'b1};
    assign period_ok = (meas == expected_period_i) && (expected_period_i != '0);

    always_comb begin
        state_d = state_q;
        match_d = match_q;
        err_inc = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (sref_rise) begin
                    state_d = ST_TRACK;
                    match_d = 8'd0;
                end
            end
            ST_TRACK: begin
                if (sref_rise) begin
                    if (period_ok) begin
                        match_d = match_q + 8'd1;
                        if (match_q == 8'(LOCK_COUNT - 1)) begin
                            state_d = ST_LOCKED;
                        end
                    end else begin
                        match_d = 8'd0;
                    end
                end else if (phase_max) begin
                    state_d = ST_IDLE;
                    match_d = 8'd0;
                end
            end
            ST_LOCKED: begin
                if (sref_rise) begin
                    if (!period_ok) begin
                        state_d = ST_TRACK;
                        match_d = 8'd0;
                        err_inc = 1'b1;
                    end
                end else if (phase_max) begin
                    state_d = ST_IDLE;
                    match_d = 8'd0;
                    err_inc = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                match_d = 8'd0;
            end
        endcase
    end

    always_ff @(posedge sysclk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q       <= ST_IDLE;
            match_q       <= 8'd0;
            sysref_q      <= 1'b0;
            live_q        <= 1'b0;
            sysref_edge_o <= 1'b0;
            phase_o       <= '0;
            period_o      <= '0;
            locked_o      <= 1'b0;
            err_count_o   <= 8'd0;
        end else begin
            state_q       <= state_d;
            match_q       <= match_d;
            sysref_q      <= pl_sysref_i;
            live_q        <= 1'b1;
            sysref_edge_o <= sref_rise;
            locked_o      <= (state_d == ST_LOCKED);

            if (sref_rise) begin
                phase_o <= '0;
            end else if (!phase_max) begin
                phase_o <= meas;
            end

            // The first edge only starts the measurement.
            if (sref_rise && (state_q != ST_IDLE)) begin
                period_o <= meas;
            end

            if (clr_err_i) begin
                err_count_o <= 8'd0;
            end else if (err_inc && (err_count_o != 8'hFF)) begin
                err_count_o <= err_count_o + 8'd1;
            end
        end
    end

`ifdef SYSREF_MON_SYNC_EN
    logic sync_fire;

    // Fires on an edge whose cycle will show locked_o=1 while an arm was
    // already pending; an arm_i in the same cycle re-arms for a later edge.
    assign sync_fire = sref_rise & armed_o & (state_d == ST_LOCKED);

    always_ff @(posedge sysclk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            armed_o <= 1'b0;
            sync_o  <= 1'b0;
        end else begin
            armed_o <= (armed_o & ~sync_fire) | arm_i;
            sync_o  <= sync_fire;
        end
    end
`else
    logic unused_arm;

    assign unused_arm = arm_i;
    assign armed_o    = 1'b0;
    assign sync_o     = 1'b0;
`endif

endmodule

// File: tb/tb_sysref_monitor.sv
module tb_sysref_monitor;

    localparam int PW    = 16;
    localparam int LC    = 8;
    localparam int PMAX  = 65535;
`ifdef SYSREF_MON_SYNC_EN
    localparam int SYNC  = 1;
`else
    localparam int SYNC  = 0;
`endif

    logic          clk;
    logic          rst_n;
    logic          pl_sysref;
    logic [PW-1:0] exp_per;
    logic          arm;
    logic          clr_err;
    logic          sysref_edge;
    logic [PW-1:0] period;
    logic [PW-1:0] phase;
    logic          locked;
    logic [7:0]    err_count;
    logic          armed;
    logic          sync;

    sysref_monitor #(.PERIOD_W(PW), .LOCK_COUNT(LC)) dut (
        .sysclk_i          (clk),
        .rst_n_i           (rst_n),
        .pl_sysref_i       (pl_sysref),
        .expected_period_i (exp_per),
        .arm_i             (arm),
        .clr_err_i         (clr_err),
        .sysref_edge_o     (sysref_edge),
        .period_o          (period),
        .phase_o           (phase),
        .locked_o          (locked),
        .err_count_o       (err_count),
        .armed_o           (armed),
        .sync_o            (sync)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int errors = 0;
    int checks = 0;

    // Reference model: edges in absolute terms, lock as a run length of
    // consecutive matching periods since acquisition.
    bit m_prev, m_first, m_seen, m_locked, m_armed, m_sync, m_edge;
    int m_phase, m_period, m_run, m_err;

    // Values captured on the rising-edge step of sref()
    int rise_edge, rise_locked, rise_sync, rise_err;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_prev = 0; m_first = 1; m_seen = 0; m_locked = 0;
        m_armed = 0; m_sync = 0; m_edge = 0;
        m_phase = 0; m_period = 0; m_run = 0; m_err = 0;
    endtask

    task automatic model_update(input bit pl, input bit a, input bit c);
        bit e, was;
        int meas;
        e = pl && !m_prev && !m_first;
        m_first = 0;
        m_prev = pl;
        was = m_locked;
        if (e) begin
            if (m_seen) begin
                meas = (m_phase + 1) % 65536;
                m_period = meas;
                if (meas == int'(exp_per) && exp_per != 0) m_run++;
                else m_run = 0;
            end else begin
                m_seen = 1;
                m_run = 0;
            end
            m_phase = 0;
        end else begin
            if (m_seen && m_phase == PMAX) begin
                m_seen = 0;
                m_run = 0;
            end
            if (m_phase < PMAX) m_phase++;
        end
        m_locked = m_seen && (m_run >= LC);
        if (c) m_err = 0;
        else if (was && !m_locked && m_err < 255) m_err++;
        if (SYNC != 0) begin
            m_sync = e && m_armed && m_locked;
            m_armed = (m_armed && !m_sync) || a;
        end else begin
            m_sync = 0;
            m_armed = 0;
        end
        m_edge = e;
    endtask

    task automatic compare_all();
        chk("edge",   int'(sysref_edge), int'(m_edge));
        chk("phase",  int'(phase),       m_phase);
        chk("period", int'(period),      m_period);
        chk("locked", int'(locked),      int'(m_locked));
        chk("err",    int'(err_count),   m_err);
        chk("armed",  int'(armed),       int'(m_armed));
        chk("sync",   int'(sync),        int'(m_sync));
    endtask

    // Called at a negedge; applies inputs for one cycle, then compares.
    task automatic step(input bit pl, input bit a, input bit c, input bit do_chk);
        pl_sysref = pl;
        arm = a;
        clr_err = c;
        @(posedge clk);
        model_update(pl, a, c);
        @(negedge clk);
        if (do_chk) compare_all();
    endtask

    // One SYSREF period of n cycles (n >= 3): 2 cycles high, then low.
    task automatic sref(input int n, input bit c);
        step(1, 0, c, 1);
        rise_edge = int'(sysref_edge);
        rise_locked = int'(locked);
        rise_sync = int'(sync);
        rise_err = int'(err_count);
        step(1, 0, 0, 1);
        for (int i = 0; i < n - 2; i++) step(0, 0, 0, 1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_edge"},   int'(sysref_edge), 0);
        chk({tag, "_phase"},  int'(phase),       0);
        chk({tag, "_period"}, int'(period),      0);
        chk({tag, "_locked"}, int'(locked),      0);
        chk({tag, "_err"},    int'(err_count),   0);
        chk({tag, "_armed"},  int'(armed),       0);
        chk({tag, "_sync"},   int'(sync),        0);
    endtask

    typedef struct {
        bit pl;
        int exp_edge;
        int exp_phase;
        int exp_period;
    } vec_t;

    vec_t tbl[10];

    initial begin
        // Post-reset sequence: edges at rows 1, 4, 9 -> periods 3 then 5
        tbl[0] = '{0, 0, 1, 0};
        tbl[1] = '{1, 1, 0, 0};
        tbl[2] = '{0, 0, 1, 0};
        tbl[3] = '{0, 0, 2, 0};
        tbl[4] = '{1, 1, 0, 3};
        tbl[5] = '{1, 0, 1, 3};
        tbl[6] = '{0, 0, 2, 3};
        tbl[7] = '{0, 0, 3, 3};
        tbl[8] = '{0, 0, 4, 3};
        tbl[9] = '{1, 1, 0, 5};

        rst_n = 1'b0;
        pl_sysref = 1'b0;
        exp_per = 16'd16;
        arm = 1'b0;
        clr_err = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            step(tbl[i].pl, 0, 0, 1);
            chk($sformatf("tbl%0d_edge", i),   int'(sysref_edge), tbl[i].exp_edge);
            chk($sformatf("tbl%0d_phase", i),  int'(phase),       tbl[i].exp_phase);
            chk($sformatf("tbl%0d_period", i), int'(period),      tbl[i].exp_period);
            chk($sformatf("tbl%0d_locked", i), int'(locked),      0);
        end

        // Arm while unlocked, then lock at period 16
        step(0, 1, 0, 1);
        chk("armed_after_arm", int'(armed), SYNC);
        for (int k = 1; k <= 9; k++) begin
            sref(16, 0);
            if (k < 9) chk($sformatf("no_sync_edge%0d", k), rise_sync, 0);
            if (k == 8) chk("unlocked_after_8th", int'(locked), 0);
        end
        chk("lock9_edge",   rise_edge,   1);
        chk("lock9_locked", rise_locked, 1);
        chk("lock9_sync",   rise_sync,   SYNC);
        chk("lock_period",  int'(period), 16);
        chk("lock_err",     int'(err_count), 0);
        chk("armed_cleared", int'(armed), 0);

        // One period of 17: loss seen at the following edge
        sref(17, 0);
        sref(16, 0);
        chk("p17_edge",   rise_edge,   1);
        chk("p17_locked", rise_locked, 0);
        chk("p17_err",    rise_err,    1);
        chk("p17_period", int'(period), 17);
        for (int k = 1; k <= 8; k++) begin
            sref(16, 0);
            if (k == 7) chk("relock_not_yet", int'(locked), 0);
        end
        chk("relock_locked", rise_locked, 1);

        // SYSREF held low until loss
        for (int i = 0; i < 70000; i++) begin
            step(0, 0, 0, 0);
            if (!locked) break;
        end
        compare_all();
        chk("loss_locked", int'(locked),    0);
        chk("loss_phase",  int'(phase),     PMAX);
        chk("loss_err",    int'(err_count), 2);

        // Drive err_count to saturation with short periods
        exp_per = 16'd4;
        for (int k = 0; k < 9; k++) sref(4, 0);
        chk("sat_lock", int'(locked), 1);
        for (int it = 0; it < 300; it++) begin
            if (m_err == 255) break;
            sref(5, 0);
            for (int k = 0; k < 9; k++) sref(4, 0);
        end
        chk("sat_reached", int'(err_count), 255);
        sref(5, 0);
        for (int k = 0; k < 9; k++) sref(4, 0);
        chk("sat_hold", rise_err, 255);
        chk("sat_hold_now", int'(err_count), 255);
        sref(5, 0);
        sref(4, 1);
        chk("clr_wins", rise_err, 0);
        chk("clr_wins_locked", rise_locked, 0);

        // Randomized traffic against the model
        for (int k = 0; k < 600; k++) begin
            int n, hi;
            if (k % 150 == 0) begin
                case ($urandom_range(0, 2))
                    0: exp_per = 16'd4;
                    1: exp_per = 16'd5;
                    default: exp_per = 16'd0;
                endcase
            end
            n = $urandom_range(4, 5);
            if ($urandom_range(0, 7) == 0) n = $urandom_range(3, 7);
            hi = $urandom_range(1, n - 1);
            for (int i = 0; i < n; i++) begin
                step(i < hi, ($urandom_range(0, 15) == 0), ($urandom_range(0, 31) == 0), 1);
            end
        end

        // Asynchronous reset while locked
        exp_per = 16'd4;
        for (int k = 0; k < 10; k++) sref(4, 0);
        chk("pre_reset_locked", int'(locked), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("async");
        pl_sysref = 1'b1;
        repeat (3) @(negedge clk);
        model_reset();
        rst_n = 1'b1;
        step(1, 0, 0, 1);
        chk("release_high_no_edge0", int'(sysref_edge), 0);
        step(1, 0, 0, 1);
        chk("release_high_no_edge1", int'(sysref_edge), 0);
        step(0, 0, 0, 1);
        step(1, 0, 0, 1);
        chk("post_release_edge", int'(sysref_edge), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
